// File: rtl/riscv_core_loader_ctrl_if.sv
// ---------------------------------------------------------------------------
// riscv_core_loader_ctrl_if
// Instruction-memory write bus between the loader controller and IMEM.
//   imem_we     one-cycle write strobe
//   imem_addr   IMEM word address (IMEM_AW bits)
//   imem_wdata  32-bit write data
// Modports: master = loader controller (drives), slave = instruction memory.
// ---------------------------------------------------------------------------
interface riscv_core_loader_ctrl_if #(
    parameter int IMEM_AW = 10
);
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/riscv_core_loader_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_core_loader_ctrl
// Converts level-held software register values into IMEM write strobes and
// a core reset/run sequence, and reports run status and a cycle count.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET   clock and synchronous active-high reset
//   i_mem_reset_n              0 = go to LOAD (core held in reset, loading on)
//   i_run_pc                   rising edge starts the core, low aborts/acks
//   i_slv_reg1 / i_slv_reg2    load byte address / load data word
//   i_slv_reg3                 [0] write toggle, [31:16] cycle limit
//   i_core_halt                core halt level
//   imem                       IMEM write bus (master modport)
//   o_core_rst, o_run_pulse    core reset and one-cycle start pulse
//   o_busy, o_done, o_timeout  run status
//   o_load_err                 sticky: write toggle changed outside LOAD
//   o_load_count               words written since entering LOAD (saturating)
//   o_cycle_count              core run cycles (saturating)
//
// Build option: define RISCV_CYCLE_LIMIT_EN to enable the cycle limit taken
// from i_slv_reg3[31:16]; otherwise o_timeout is constant 0.
//
// state  | meaning
// LOAD   | core in reset, IMEM writes accepted
// IDLE   | core in reset, waiting for run edge
// START  | one-cycle start pulse, counter cleared
// RUN    | core running, counting cycles
// DONE   | halted or limit reached, count frozen
// ---------------------------------------------------------------------------
module riscv_core_loader_ctrl #(
    parameter int IMEM_AW = 10,
    parameter int CNT_W   = 32
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESET,
    input  logic                     i_mem_reset_n,
    input  logic                     i_run_pc,
    input  logic [31:0]              i_slv_reg1,
    input  logic [31:0]              i_slv_reg2,
    input  logic [31:0]              i_slv_reg3,
    input  logic                     i_core_halt,
    riscv_core_loader_ctrl_if.master imem,
    output logic                     o_core_rst,
    output logic                     o_run_pulse,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic                     o_load_err,
    output logic [IMEM_AW:0]         o_load_count,
    output logic [CNT_W-1:0]         o_cycle_count
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic tog_prev;
    logic run_prev;
    logic tog_chg;
    logic run_rise;
    logic limit_hit;
    logic cnt_inc;
    logic enter_load;
    logic timeout_q;
    logic unused_bits;

    assign tog_chg  = (tog_prev != i_slv_reg3[0]);
    assign run_rise = i_run_pc && !run_prev;

`ifdef RISCV_CYCLE_LIMIT_EN
    assign limit_hit = (state == S_RUN) && (i_slv_reg3[31:16] != 16'd0) &&
                       (o_cycle_count == CNT_W'(i_slv_reg3[31:16]));
    assign unused_bits = ^{i_slv_reg1[31:IMEM_AW+2], i_slv_reg1[1:0], i_slv_reg3[15:1]};
`else
    assign limit_hit = 1'b0;
    assign unused_bits = ^{i_slv_reg1[31:IMEM_AW+2], i_slv_reg1[1:0], i_slv_reg3[31:1]};
`endif

    // A limit exit freezes the count at the limit; a halt cycle is always counted.
    assign cnt_inc    = (state == S_RUN) && i_mem_reset_n && !(limit_hit && !i_core_halt);
    assign enter_load = (state_nxt == S_LOAD) && (state != S_LOAD);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_core_rst  = 1'b1;
        o_run_pulse = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        if (!i_mem_reset_n) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  state_nxt = S_IDLE;
                S_IDLE:  if (run_rise) state_nxt = S_START;
                S_START: state_nxt = S_RUN;
                S_RUN: begin
                    if (i_core_halt || limit_hit) state_nxt = S_DONE;
                    else if (!i_run_pc)           state_nxt = S_IDLE;
                end
                S_DONE:  if (!i_run_pc) state_nxt = S_IDLE;
                default: state_nxt = S_LOAD;
            endcase
        end
        case (state)
            S_START: begin
                o_core_rst  = 1'b0;
                o_run_pulse = 1'b1;
                o_busy      = 1'b1;
            end
            S_RUN: begin
                o_core_rst = 1'b0;
                o_busy     = 1'b1;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_timeout = timeout_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            tog_prev        <= i_slv_reg3[0];
            run_prev        <= i_run_pc;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
            o_load_count    <= '0;
            o_load_err      <= 1'b0;
            o_cycle_count   <= '0;
            timeout_q       <= 1'b0;
        end else begin
            tog_prev     <= i_slv_reg3[0];
            run_prev     <= i_run_pc;
            imem.imem_we <= 1'b0;

            if (tog_chg) begin
                if (state == S_LOAD) begin
                    imem.imem_we    <= 1'b1;
                    imem.imem_addr  <= i_slv_reg1[IMEM_AW+1:2];
                    imem.imem_wdata <= i_slv_reg2;
                    if (o_load_count != '1) o_load_count <= o_load_count + 1'b1;
                end else begin
                    o_load_err <= 1'b1;
                end
            end
            // Entering LOAD takes priority over an error raised in the same cycle.
            if (enter_load) begin
                o_load_count <= '0;
                o_load_err   <= 1'b0;
            end

            if (state == S_START) begin
                o_cycle_count <= '0;
            end else if (cnt_inc && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + 1'b1;
            end

            if (state == S_RUN && state_nxt == S_DONE) begin
                timeout_q <= limit_hit && !i_core_halt;
            end else if (state_nxt != S_DONE) begin
                timeout_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_loader_ctrl.sv
module tb_riscv_core_loader_ctrl;

    localparam int IMEM_AW = 10;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [IMEM_AW-1:0] addr;
        logic [31:0]        data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               mem_reset_n;
    logic               run_pc;
    logic [31:0]        reg1, reg2, reg3;
    logic               core_halt;
    logic               core_rst, run_pulse, busy, done, timeout, load_err;
    logic [IMEM_AW:0]   load_count;
    logic [CNT_W-1:0]   cycle_count;

    int  checks   = 0;
    int  failures = 0;
    int  we_cnt   = 0;
    int  pulse_cnt = 0;
    wr_t exp_q[$];
    wr_t exp_e;

    riscv_core_loader_ctrl_if #(.IMEM_AW(IMEM_AW)) bus ();

    riscv_core_loader_ctrl #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .i_mem_reset_n (mem_reset_n),
        .i_run_pc      (run_pc),
        .i_slv_reg1    (reg1),
        .i_slv_reg2    (reg2),
        .i_slv_reg3    (reg3),
        .i_core_halt   (core_halt),
        .imem          (bus),
        .o_core_rst    (core_rst),
        .o_run_pulse   (run_pulse),
        .o_busy        (busy),
        .o_done        (done),
        .o_timeout     (timeout),
        .o_load_err    (load_err),
        .o_load_count  (load_count),
        .o_cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one load write and record what IMEM should receive.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        reg1 = addr;
        reg2 = data;
        reg3[0] = ~reg3[0];
        w.addr = addr[IMEM_AW+1:2];
        w.data = data;
        exp_q.push_back(w);
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check_val("we_unexpected", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check_val("imem_addr", 64'(bus.imem_addr), 64'(exp_e.addr));
                check_val("imem_wdata", 64'(bus.imem_wdata), 64'(exp_e.data));
            end
        end
        if (run_pulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_reset_n = 1'b0; run_pc = 1'b0;
        reg1 = '0; reg2 = '0; reg3 = '0; core_halt = 1'b0;
        repeat (3) tick();

        check_val("rst_core_rst", 64'(core_rst), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_timeout", 64'(timeout), 64'd0);
        check_val("rst_load_err", 64'(load_err), 64'd0);
        check_val("rst_load_count", 64'(load_count), 64'd0);
        check_val("rst_cycle_count", 64'(cycle_count), 64'd0);
        check_val("rst_we", 64'(bus.imem_we), 64'd0);
        check_val("rst_run_pulse", 64'(run_pulse), 64'd0);

        rst = 1'b0;
        tick();

        // single write in LOAD
        do_write(32'h0000_0008, 32'hDEAD_BEEF);
        tick();
        check_val("wr1_we", 64'(bus.imem_we), 64'd1);
        check_val("wr1_load_count", 64'(load_count), 64'd1);
        tick();
        check_val("wr1_we_single", 64'(bus.imem_we), 64'd0);

        // three back-to-back toggles, including top-word and wrapping addresses
        do_write(32'h0000_1FFC, $urandom);
        tick();
        do_write(32'hABCD_1000, $urandom);
        tick();
        do_write(32'h0000_0014, $urandom);
        tick();
        tick();
        check_val("b2b_load_count", 64'(load_count), 64'd4);
        check_val("b2b_we_cnt", 64'(we_cnt), 64'd4);

        // toggle outside LOAD
        mem_reset_n = 1'b1;
        tick();
        tick();
        reg3[0] = ~reg3[0];
        tick();
        tick();
        check_val("idle_load_err", 64'(load_err), 64'd1);
        check_val("idle_we_cnt", 64'(we_cnt), 64'd4);
        check_val("idle_core_rst", 64'(core_rst), 64'd1);

        // run, halt after 100 RUN cycles
        run_pc = 1'b1;
        tick();
        check_val("start_pulse", 64'(run_pulse), 64'd1);
        check_val("start_core_rst", 64'(core_rst), 64'd0);
        check_val("start_busy", 64'(busy), 64'd1);
        tick();
        check_val("run_pulse_off", 64'(run_pulse), 64'd0);
        check_val("run_count0", 64'(cycle_count), 64'd0);
        repeat (99) tick();
        check_val("run_count99", 64'(cycle_count), 64'd99);
        core_halt = 1'b1;
        tick();
        check_val("halt_done", 64'(done), 64'd1);
        check_val("halt_count", 64'(cycle_count), 64'd100);
        check_val("halt_busy", 64'(busy), 64'd0);
        check_val("halt_core_rst", 64'(core_rst), 64'd1);
        check_val("halt_timeout", 64'(timeout), 64'd0);
        core_halt = 1'b0;
        tick();
        check_val("done_count_frozen", 64'(cycle_count), 64'd100);
        run_pc = 1'b0;
        tick();
        check_val("ack_done", 64'(done), 64'd0);

        // mem_reset_n low mid-RUN
        run_pc = 1'b1;
        tick();
        tick();
        repeat (10) tick();
        check_val("abort_pre_count", 64'(cycle_count), 64'd10);
        mem_reset_n = 1'b0;
        tick();
        check_val("abort_core_rst", 64'(core_rst), 64'd1);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_load_count", 64'(load_count), 64'd0);
        check_val("abort_load_err", 64'(load_err), 64'd0);
        check_val("abort_count_held", 64'(cycle_count), 64'd10);
        check_val("abort_pulses", 64'(pulse_cnt), 64'd2);

        // cycle limit
        mem_reset_n = 1'b1;
        run_pc = 1'b0;
        tick();
        tick();
        reg3[31:16] = 16'd50;
        run_pc = 1'b1;
        tick();
        tick();
`ifdef RISCV_CYCLE_LIMIT_EN
        for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
        check_val("limit_done", 64'(done), 64'd1);
        check_val("limit_timeout", 64'(timeout), 64'd1);
        check_val("limit_count", 64'(cycle_count), 64'd50);
        run_pc = 1'b0;
        tick();
        check_val("limit_ack_done", 64'(done), 64'd0);
        check_val("limit_ack_timeout", 64'(timeout), 64'd0);
`else
        repeat (60) tick();
        check_val("nolimit_busy", 64'(busy), 64'd1);
        check_val("nolimit_timeout", 64'(timeout), 64'd0);
        check_val("nolimit_count", 64'(cycle_count), 64'd60);
        run_pc = 1'b0;
        tick();
        check_val("nolimit_abort_busy", 64'(busy), 64'd0);
`endif
        reg3[31:16] = 16'd0;

        // reset with toggle changed and run high: no write, no start
        rst = 1'b1;
        reg3[0] = ~reg3[0];
        run_pc = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("postrst_busy", 64'(busy), 64'd0);
        check_val("postrst_pulses", 64'(pulse_cnt), 64'd3);
        check_val("postrst_we_cnt", 64'(we_cnt), 64'd4);
        check_val("postrst_load_err", 64'(load_err), 64'd0);
        check_val("postrst_core_rst", 64'(core_rst), 64'd1);

        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
